// File: rtl/uart_tx_fifo_hs.sv
// uart_tx_fifo_hs: LSU-to-UART TX circular buffer with a
// first-word-fall-through valid/ready read side.
module uart_tx_fifo_hs #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 64,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       almost_full,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [LW-1:0] LV_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LV_AF   = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] LV_AE   = LW'(AEMPTY_THRESH);
  localparam logic [LW-1:0] LV_ONE  = LW'(1);
  localparam logic [AW-1:0] PT_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  // Flags are plain compares of the registered occupancy.
  assign full         = (level == LV_FULL);
  assign empty        = (level == '0);
  assign almost_full  = (level >= LV_AF);
  assign almost_empty = (level <= LV_AE);
  assign rd_valid     = ~empty;

  // Flush wins over both sides; full/empty gate on registered state.
  assign push = wr_en & ~full & ~flush;
  assign pop  = rd_valid & rd_ready & ~flush;

  // Head of queue falls through without a read cycle.
  assign rd_data = mem[rd_ptr];

  // Storage array, intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Read and write pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PT_ONE;
      if (pop)  rd_ptr <= rd_ptr + PT_ONE;
    end
  end

  // Occupancy counter kept independently of the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (flush) begin
      level <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level <= level + LV_ONE;
        2'b01:   level <= level - LV_ONE;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en & full & ~flush) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_hs.sv
// tb_uart_tx_fifo_hs: directed vector table plus hand sequences
// for uart_tx_fifo_hs at DEPTH=8, AFULL=6, AEMPTY=2.
module tb_uart_tx_fifo_hs;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          empty;
  logic          almost_empty;
  logic [3:0]    level;
  logic          overflow;
  logic          overflow_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_hs #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DP),
    .AFULL_THRESH (AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .almost_full (almost_full),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .empty       (empty),
    .almost_empty(almost_empty),
    .level       (level),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          fl;
    logic          we;
    logic [DW-1:0] wd;
    logic          rr;
    logic          oc;
    int            lvl;
    logic [DW-1:0] dat;
    logic          ovf;
  } vec_t;

  vec_t vt[$];

  function automatic void add(
    input logic fl, input logic we,
    input logic [DW-1:0] wd, input logic rr,
    input logic oc, input int lvl,
    input logic [DW-1:0] dat, input logic ovf
  );
    vec_t v;
    v.fl = fl; v.we = we; v.wd = wd;
    v.rr = rr; v.oc = oc; v.lvl = lvl;
    v.dat = dat; v.ovf = ovf;
    vt.push_back(v);
  endfunction

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h",
               nm, idx, act, exp);
    end
  endtask

  // Compare every output against an expected level/head/overflow.
  task automatic chk_state(
    input int idx, input int lvl,
    input logic [DW-1:0] dat, input logic ovf
  );
    chk("level", idx, 32'(level), 32'(lvl));
    chk("empty", idx, 32'(empty), 32'(lvl == 0));
    chk("rd_valid", idx, 32'(rd_valid), 32'(lvl != 0));
    chk("full", idx, 32'(full), 32'(lvl == DP));
    chk("almost_full", idx, 32'(almost_full), 32'(lvl >= AF));
    chk("almost_empty", idx, 32'(almost_empty), 32'(lvl <= AE));
    chk("overflow", idx, 32'(overflow), 32'(ovf));
    if (lvl != 0) chk("rd_data", idx, 32'(rd_data), 32'(dat));
  endtask

  task automatic idle_inputs();
    flush = 1'b0; wr_en = 1'b0; wr_data = '0;
    rd_ready = 1'b0; overflow_clr = 1'b0;
  endtask

  initial begin
    // In-order push then drain, with a stall cycle.
    add(0, 1, 8'h11, 0, 0, 1, 8'h11, 0);
    add(0, 1, 8'h22, 0, 0, 2, 8'h11, 0);
    add(0, 1, 8'h33, 0, 0, 3, 8'h11, 0);
    add(0, 0, 8'h00, 0, 0, 3, 8'h11, 0);
    add(0, 0, 8'h00, 1, 0, 2, 8'h22, 0);
    add(0, 0, 8'h00, 1, 0, 1, 8'h33, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    // Empty with push and ready: push only.
    add(0, 1, 8'h77, 1, 0, 1, 8'h77, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    // Fill, overflow, clear, full+pop rejects the write.
    for (int k = 0; k < 8; k++)
      add(0, 1, 8'(k), 0, 0, k + 1, 8'h00, 0);
    add(0, 1, 8'hAA, 0, 0, 8, 8'h00, 1);
    add(0, 0, 8'h00, 0, 1, 8, 8'h00, 0);
    add(0, 1, 8'hBB, 1, 0, 7, 8'h01, 1);
    for (int j = 2; j <= 8; j++)
      add(0, 0, 8'h00, 1, 0, 8 - j, 8'(j), 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 0);
    // Set beats clear; flush keeps overflow.
    for (int k = 0; k < 8; k++)
      add(0, 1, 8'(8'h20 + k), 0, 0, k + 1, 8'h20, 0);
    add(0, 1, 8'hCC, 0, 1, 8, 8'h20, 1);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 0);
    // Wrap-around with level held at 3.
    add(0, 1, 8'h3D, 0, 0, 1, 8'h3D, 0);
    add(0, 1, 8'h3E, 0, 0, 2, 8'h3D, 0);
    add(0, 1, 8'h3F, 0, 0, 3, 8'h3D, 0);
    for (int i = 0; i < 20; i++)
      add(0, 1, 8'(8'h40 + i), 1, 0, 3,
          (i == 0) ? 8'h3E :
          (i == 1) ? 8'h3F : 8'(8'h40 + i - 2), 0);
    // Flush at level 5 with write and read requests.
    add(0, 1, 8'h60, 0, 0, 4, 8'h51, 0);
    add(0, 1, 8'h61, 0, 0, 5, 8'h51, 0);
    add(1, 1, 8'h55, 1, 0, 0, 8'h00, 0);
    add(0, 1, 8'h12, 0, 0, 1, 8'h12, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);

    // Reset state.
    idle_inputs();
    #2 rst_n = 1'b0;
    #3 chk_state(-1, 0, 8'h00, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vt[n]) begin
      @(negedge clk);
      flush = vt[n].fl; wr_en = vt[n].we;
      wr_data = vt[n].wd; rd_ready = vt[n].rr;
      overflow_clr = vt[n].oc;
      @(posedge clk);
      #1 chk_state(n, vt[n].lvl, vt[n].dat, vt[n].ovf);
    end

    // Mid-burst asynchronous reset at level 4.
    @(negedge clk) idle_inputs();
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + k);
      @(negedge clk);
    end
    chk_state(100, 4, 8'h80, 0);
    #2 rst_n = 1'b0;
    #1 chk_state(101, 0, 8'h00, 0);
    @(posedge clk);
    #1 chk_state(102, 0, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    @(posedge clk);
    #1 chk_state(103, 1, 8'h99, 0);
    @(negedge clk);
    wr_en = 1'b0; rd_ready = 1'b1;
    @(posedge clk);
    #1 chk_state(104, 0, 8'h00, 0);
    @(negedge clk) idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
